// File: rtl/fetch_queue_if.sv
// fetch_queue_if
//   Bundles every non-clock, non-reset signal of the fetch front end:
//   the program-counter handshake, the instruction-memory request/response
//   channel, the IF/ID delivery channel and the sticky error flag.
//   Signal names keep their _i/_o suffixes as seen from fetch_queue.
// Modports
//   master : fetch_queue side (drives req/addr/pc_write/inst/err)
//   slave  : environment side (PC, imem, IF/ID stage)
interface fetch_queue_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] pc_i;
  logic              pc_write_o;
  logic              flush_i;
  logic              imem_req_o;
  logic [ADDR_W-1:0] imem_addr_o;
  logic              imem_gnt_i;
  logic              imem_rvalid_i;
  logic [DATA_W-1:0] imem_rdata_i;
  logic              inst_valid_o;
  logic [DATA_W-1:0] inst_o;
  logic [ADDR_W-1:0] inst_pc_o;
  logic              inst_ready_i;
  logic              err_o;

  modport master (
    input  pc_i, flush_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, inst_ready_i,
    output pc_write_o, imem_req_o, imem_addr_o, inst_valid_o, inst_o, inst_pc_o, err_o
  );

  modport slave (
    output pc_i, flush_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, inst_ready_i,
    input  pc_write_o, imem_req_o, imem_addr_o, inst_valid_o, inst_o, inst_pc_o, err_o
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue
//   Instruction-fetch front end. Issues the current PC as an imem request,
//   advances the PC only when the request is granted, buffers in-order
//   responses (tagged with their PC) in a DEPTH-entry circular queue and
//   presents the head entry to IF/ID over valid/ready. A flush discards the
//   queue and remembers how many in-flight responses must be thrown away.
// Ports
//   clk_i  : clock, rising edge
//   rst_i  : asynchronous active-low reset
//   bus    : fetch_queue_if.master (PC, imem, IF/ID and error signals)
module fetch_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  fetch_queue_if.master bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0]  alloc_ptr;
  logic [PTR_W-1:0]  fill_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  alloc_cnt;
  logic [CNT_W-1:0]  pend_cnt;
  logic [CNT_W-1:0]  drop_cnt;
  logic [CNT_W:0]    infl;
  logic [DEPTH-1:0]  filled;
  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic              req;
  logic              accept;
  logic              pop;
  logic              resp_drop;
  logic              resp_keep;
  logic              resp_err;
  logic              resp_any;
  logic              err_q;

  // In-flight = requested but not yet answered, whether the answer will be
  // kept (pend_cnt) or thrown away after a flush (drop_cnt).
  assign infl = {1'b0, pend_cnt} + {1'b0, drop_cnt};

  // Reset gates the request so the handshake outputs drop immediately when
  // rst_i falls, not just once the counters have cleared.
  assign req    = rst_i & ~bus.flush_i & (alloc_cnt < DEPTH_CNT) & (infl < {1'b0, DEPTH_CNT});
  assign accept = req & bus.imem_gnt_i;
  assign pop    = filled[rd_ptr] & bus.inst_ready_i;

  // Responses owed to flushed requests are consumed first.
  assign resp_drop = bus.imem_rvalid_i & (drop_cnt != '0);
  assign resp_keep = bus.imem_rvalid_i & (drop_cnt == '0) & (pend_cnt != '0);
  assign resp_err  = bus.imem_rvalid_i & (drop_cnt == '0) & (pend_cnt == '0);
  assign resp_any  = resp_drop | resp_keep;

  assign bus.imem_req_o   = req;
  assign bus.imem_addr_o  = bus.pc_i;
  assign bus.pc_write_o   = accept;
  assign bus.inst_valid_o = filled[rd_ptr];
  assign bus.inst_o       = data_mem[rd_ptr];
  assign bus.inst_pc_o    = pc_mem[rd_ptr];
  assign bus.err_o        = err_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      rd_ptr    <= '0;
      alloc_cnt <= '0;
      pend_cnt  <= '0;
      drop_cnt  <= '0;
      filled    <= '0;
    end else if (bus.flush_i) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      rd_ptr    <= '0;
      alloc_cnt <= '0;
      pend_cnt  <= '0;
      filled    <= '0;
      // Every response still owed (pending or already dropped) must be
      // discarded later, minus the one arriving right now.
      drop_cnt  <= drop_cnt + pend_cnt - CNT_W'(resp_any);
    end else begin
      if (accept)    alloc_ptr <= alloc_ptr + PTR_W'(1);
      if (resp_keep) fill_ptr  <= fill_ptr + PTR_W'(1);
      if (pop)       rd_ptr    <= rd_ptr + PTR_W'(1);
      alloc_cnt <= alloc_cnt + CNT_W'(accept) - CNT_W'(pop);
      pend_cnt  <= pend_cnt + CNT_W'(accept) - CNT_W'(resp_keep);
      if (resp_drop) drop_cnt <= drop_cnt - CNT_W'(1);
      // fill_ptr never equals rd_ptr of a filled entry, so set/clear never collide.
      if (resp_keep) filled[fill_ptr] <= 1'b1;
      if (pop)       filled[rd_ptr]   <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      err_q <= 1'b0;
    end else if (resp_err) begin
      err_q <= 1'b1;
    end
  end

  // Payload storage needs no reset; validity is tracked by the filled bits.
  always_ff @(posedge clk_i) begin
    if (accept) pc_mem[alloc_ptr] <= bus.pc_i;
    if (resp_keep && !bus.flush_i) data_mem[fill_ptr] <= bus.imem_rdata_i;
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue
//   Self-checking bench for fetch_queue. Plays the program counter, the
//   instruction memory (in-order responses, rdata derived from the address)
//   and the IF/ID consumer. A queue-based reference model is compared with
//   the DUT on every falling edge; directed scenarios add literal checks.
module tb_fetch_queue;
  localparam int DEPTH = 4;

  logic clk_i = 1'b0;
  logic rst_i;

  fetch_queue_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  fetch_queue #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  int tests  = 0;
  int failed = 0;

  // Reference model: allocated PCs in order, data of the filled prefix,
  // responses still owed to flushed requests, sticky error.
  logic [31:0] pcq    [$];
  logic [31:0] dataq  [$];
  logic [31:0] imem_q [$];
  int          drop   = 0;
  bit          merr   = 1'b0;
  logic [31:0] pc_reg = '0;
  logic [31:0] redirect_pc = '0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one cycle of inputs shortly after the rising edge.
  task automatic applyStimulus(input bit gnt, input bit ready, input bit rv_en,
                               input bit flush, input bit spur, input bit rst_drop,
                               input logic [31:0] target);
    @(posedge clk_i);
    #1;
    rst_i            = !rst_drop;
    bus.pc_i         = pc_reg;
    bus.imem_gnt_i   = gnt;
    bus.inst_ready_i = ready;
    bus.flush_i      = flush;
    redirect_pc      = target;
    if (imem_q.size() > 0) begin
      bus.imem_rvalid_i = rv_en;
      bus.imem_rdata_i  = memf(imem_q[0]);
    end else begin
      bus.imem_rvalid_i = spur;
      bus.imem_rdata_i  = $urandom;
    end
  endtask

  // Per-cycle comparison against the model, then model advance.
  always @(negedge clk_i) begin : cmp_proc
    int unf;
    bit exp_req;
    bit exp_pw;
    bit exp_valid;
    bit do_pop;
    if (!rst_i) begin
      checkOutput("rst_req", bus.imem_req_o, 0);
      checkOutput("rst_pc_write", bus.pc_write_o, 0);
      checkOutput("rst_valid", bus.inst_valid_o, 0);
      checkOutput("rst_err", bus.err_o, 0);
      pcq.delete();
      dataq.delete();
      imem_q.delete();
      drop = 0;
      merr = 1'b0;
    end else begin
      unf       = pcq.size() - dataq.size();
      exp_req   = !bus.flush_i && (pcq.size() < DEPTH) && ((unf + drop) < DEPTH);
      exp_pw    = exp_req && bus.imem_gnt_i;
      exp_valid = dataq.size() > 0;
      checkOutput("req", bus.imem_req_o, exp_req);
      checkOutput("pc_write", bus.pc_write_o, exp_pw);
      checkOutput("addr", bus.imem_addr_o, bus.pc_i);
      checkOutput("valid", bus.inst_valid_o, exp_valid);
      checkOutput("err", bus.err_o, merr);
      if (exp_valid) begin
        checkOutput("inst", bus.inst_o, dataq[0]);
        checkOutput("inst_pc", bus.inst_pc_o, pcq[0]);
      end
      do_pop = exp_valid && bus.inst_ready_i;
      if (bus.imem_rvalid_i) begin
        if (imem_q.size() > 0) void'(imem_q.pop_front());
        if (drop > 0)       drop--;
        else if (unf > 0) begin
          if (bus.flush_i) unf--;
          else dataq.push_back(bus.imem_rdata_i);
        end else merr = 1'b1;
      end
      if (bus.flush_i) begin
        drop += unf;
        pcq.delete();
        dataq.delete();
        pc_reg = redirect_pc;
      end else begin
        if (do_pop) begin
          void'(pcq.pop_front());
          void'(dataq.pop_front());
        end
        if (exp_pw) begin
          pcq.push_back(bus.pc_i);
          imem_q.push_back(bus.pc_i);
          pc_reg = pc_reg + 32'd4;
        end
      end
    end
  end

  initial begin : stim
    int grants;
    bit got;
    rst_i             = 1'b0;
    bus.pc_i          = '0;
    bus.flush_i       = 1'b0;
    bus.imem_gnt_i    = 1'b0;
    bus.imem_rvalid_i = 1'b0;
    bus.imem_rdata_i  = '0;
    bus.inst_ready_i  = 1'b0;

    applyStimulus(0, 0, 0, 0, 0, 1, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 0, 32'h0);

    // Spurious response with nothing outstanding.
    applyStimulus(0, 0, 0, 0, 1, 0, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 0, 32'h0);
    #1;
    checkOutput("t6_err", bus.err_o, 1);
    checkOutput("t6_valid", bus.inst_valid_o, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 0, 32'h0);
    #1;
    checkOutput("t6_err_cleared", bus.err_o, 0);

    // Streaming: one response per cycle, consumer always ready.
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1, 1, 1, 0, 0, 0, 32'h0);
      #1;
      checkOutput("t2_pc_write", bus.pc_write_o, 1);
      if (k >= 2) begin
        checkOutput("t2_valid", bus.inst_valid_o, 1);
        checkOutput("t2_inst_pc", bus.inst_pc_o, 32'(4 * (k - 2)));
        checkOutput("t2_inst", bus.inst_o, memf(32'(4 * (k - 2))));
      end
    end

    // Reset dropped between edges while streaming.
    applyStimulus(1, 1, 1, 0, 0, 0, 32'h0);
    #2;
    rst_i = 1'b0;
    #1;
    checkOutput("t1_req", bus.imem_req_o, 0);
    checkOutput("t1_pc_write", bus.pc_write_o, 0);
    checkOutput("t1_valid", bus.inst_valid_o, 0);
    checkOutput("t1_err", bus.err_o, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 0, 32'h0);
    #1;
    checkOutput("t1_req_resume", bus.imem_req_o, 1);
    checkOutput("t1_addr_resume", bus.imem_addr_o, 32'd24);

    // Backpressure: consumer stalled, queue fills to DEPTH.
    grants = 0;
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1, 0, 1, 0, 0, 0, 32'h0);
      #1;
      if (bus.pc_write_o === 1'b1) grants++;
    end
    checkOutput("t3_grants", grants, DEPTH);
    checkOutput("t3_req_full", bus.imem_req_o, 0);
    checkOutput("t3_pc_held", bus.pc_i, 32'd40);
    applyStimulus(1, 1, 1, 0, 0, 0, 32'h0);
    #1;
    checkOutput("t3_pop_cycle_pw", bus.pc_write_o, 0);
    applyStimulus(1, 0, 1, 0, 0, 0, 32'h0);
    #1;
    checkOutput("t3_refill_pw", bus.pc_write_o, 1);
    applyStimulus(1, 0, 1, 0, 0, 0, 32'h0);
    #1;
    checkOutput("t3_full_again", bus.imem_req_o, 0);

    // Grant stall: PC must not advance.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 1, 1, 0, 0, 0, 32'h0);
      #1;
      checkOutput("t4_pc_write", bus.pc_write_o, 0);
      checkOutput("t4_addr", bus.imem_addr_o, 32'd44);
    end
    for (int k = 0; k < 6; k++) applyStimulus(0, 1, 1, 0, 0, 0, 32'h0);

    // Flush with two requests in flight, redirect to 0x100.
    applyStimulus(1, 1, 0, 0, 0, 0, 32'h0);
    applyStimulus(1, 1, 0, 0, 0, 0, 32'h0);
    applyStimulus(1, 1, 0, 1, 0, 0, 32'h100);
    #1;
    checkOutput("t5_req_flush", bus.imem_req_o, 0);
    applyStimulus(1, 0, 1, 0, 0, 0, 32'h0);
    #1;
    checkOutput("t5_valid_after", bus.inst_valid_o, 0);
    checkOutput("t5_addr_redirect", bus.imem_addr_o, 32'h100);
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      applyStimulus(1, 0, 1, 0, 0, 0, 32'h0);
      #1;
      if (bus.inst_valid_o === 1'b1) got = 1'b1;
    end
    checkOutput("t5_delivered", got, 1);
    checkOutput("t5_inst_pc", bus.inst_pc_o, 32'h100);
    checkOutput("t5_inst", bus.inst_o, memf(32'h100));

    // Randomized traffic with occasional flushes, spurious responses and resets.
    for (int i = 0; i < 1500; i++) begin
      applyStimulus($urandom_range(99) < 70, $urandom_range(99) < 70,
                    $urandom_range(99) < 60, $urandom_range(99) < 4,
                    $urandom_range(99) < 2, $urandom_range(99) < 1,
                    $urandom & 32'hFFFF_FFFC);
    end
    applyStimulus(0, 1, 1, 0, 0, 0, 32'h0);
    @(posedge clk_i);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
